// File: rtl/race_controller.sv
// race_controller: drag-race game-flow sequencer (IDLE -> COUNTDOWN -> RACE -> FINISH).
// Turns throttle key presses into frame-paced car motion, detects false starts,
// the finish line and the winner. All outputs are registered.
module race_controller #(
  parameter logic [10:0] START_X      = 11'd256,
  parameter logic [10:0] FINISH_X     = 11'd900,
  parameter logic [3:0]  MAX_SPEED    = 4'd15,
  parameter int unsigned STEP_FRAMES  = 60,
  parameter int unsigned DECAY_FRAMES = 8,
  parameter logic [3:0]  KEY_P1       = 4'h1,
  parameter logic [3:0]  KEY_P2       = 4'h2,
  parameter logic [3:0]  KEY_ENTER    = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        frame_tick,
  input  logic [3:0]  key_code,
  output logic [10:0] xpos_p1,
  output logic [10:0] xpos_p2,
  output logic [1:0]  countdown,
  output logic        race_active,
  output logic [1:0]  winner,
  output logic        done,
  output logic        back_to_menu
);

  localparam int unsigned FW = $clog2(STEP_FRAMES + 1);
  localparam int unsigned DW = $clog2(DECAY_FRAMES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CD     = 2'd1;
  localparam logic [1:0] S_RACE   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    r_state;
  logic [10:0]   r_xpos_p1, r_xpos_p2;
  logic [3:0]    r_speed_p1, r_speed_p2;
  logic [FW-1:0] r_frame_cnt;
  logic [DW-1:0] r_decay_cnt;
  logic [1:0]    r_countdown;
  logic [1:0]    r_winner;
  logic          r_race_active, r_done, r_back_to_menu;

  logic [1:0]    w_state;
  logic [10:0]   w_xpos_p1, w_xpos_p2;
  logic [3:0]    w_speed_p1, w_speed_p2;
  logic [FW-1:0] w_frame_cnt;
  logic [DW-1:0] w_decay_cnt;
  logic [1:0]    w_countdown;
  logic [1:0]    w_winner;
  logic          w_back_to_menu;
  logic [11:0]   w_sum_p1, w_sum_p2;
  logic [10:0]   w_clamp_p1, w_clamp_p2;
  logic          w_decay, w_press_p1, w_press_p2;
  logic          w_fin_p1, w_fin_p2;

  // Speed update: press and decay cancel; press saturates; decay floors at zero.
  function automatic logic [3:0] f_next_speed(input logic [3:0] s, input logic press,
                                              input logic decay);
    logic [3:0] r;
    r = s;
    if (press && !decay) begin
      if (s < MAX_SPEED) r = s + 4'd1;
    end else if (decay && !press) begin
      if (s != 4'd0) r = s - 4'd1;
    end
    return r;
  endfunction

  // Position candidates use the speed held before this cycle's update.
  assign w_sum_p1   = {1'b0, r_xpos_p1} + {8'd0, r_speed_p1};
  assign w_sum_p2   = {1'b0, r_xpos_p2} + {8'd0, r_speed_p2};
  assign w_clamp_p1 = (w_sum_p1 >= {1'b0, FINISH_X}) ? FINISH_X : w_sum_p1[10:0];
  assign w_clamp_p2 = (w_sum_p2 >= {1'b0, FINISH_X}) ? FINISH_X : w_sum_p2[10:0];
  assign w_press_p1 = (key_code == KEY_P1);
  assign w_press_p2 = (key_code == KEY_P2);
  // Decay fires on the tick that finds the counter already at DECAY_FRAMES.
  assign w_decay    = frame_tick && (r_decay_cnt == DW'(DECAY_FRAMES));

  // Next-state and next-output logic.
  always_comb begin
    w_state        = r_state;
    w_xpos_p1      = r_xpos_p1;
    w_xpos_p2      = r_xpos_p2;
    w_speed_p1     = r_speed_p1;
    w_speed_p2     = r_speed_p2;
    w_frame_cnt    = r_frame_cnt;
    w_decay_cnt    = r_decay_cnt;
    w_countdown    = r_countdown;
    w_winner       = r_winner;
    w_back_to_menu = 1'b0;
    w_fin_p1       = 1'b0;
    w_fin_p2       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_xpos_p1  = START_X;
        w_xpos_p2  = START_X;
        w_speed_p1 = 4'd0;
        w_speed_p2 = 4'd0;
        if (start_game) begin
          w_state     = S_CD;
          w_countdown = 2'd3;
          w_frame_cnt = '0;
          w_winner    = 2'b00;
        end
      end
      S_CD: begin
        if (w_press_p1) begin
          w_state  = S_FINISH;
          w_winner = 2'b10;
        end else if (w_press_p2) begin
          w_state  = S_FINISH;
          w_winner = 2'b01;
        end else if (frame_tick) begin
          if (r_frame_cnt == FW'(STEP_FRAMES - 1)) begin
            w_frame_cnt = '0;
            w_countdown = r_countdown - 2'd1;
            if (r_countdown == 2'd1) w_state = S_RACE;
          end else begin
            w_frame_cnt = r_frame_cnt + FW'(1);
          end
        end
      end
      S_RACE: begin
        w_speed_p1 = f_next_speed(r_speed_p1, w_press_p1, w_decay);
        w_speed_p2 = f_next_speed(r_speed_p2, w_press_p2, w_decay);
        if (frame_tick) begin
          w_xpos_p1   = w_clamp_p1;
          w_xpos_p2   = w_clamp_p2;
          w_decay_cnt = w_decay ? '0 : r_decay_cnt + DW'(1);
          w_fin_p1    = (w_clamp_p1 == FINISH_X);
          w_fin_p2    = (w_clamp_p2 == FINISH_X);
        end
        if (w_fin_p1 || w_fin_p2) begin
          w_state  = S_FINISH;
          w_winner = {w_fin_p2, w_fin_p1};
        end
      end
      S_FINISH: begin
        if (key_code == KEY_ENTER) begin
          w_state        = S_IDLE;
          w_xpos_p1      = START_X;
          w_xpos_p2      = START_X;
          w_speed_p1     = 4'd0;
          w_speed_p2     = 4'd0;
          w_frame_cnt    = '0;
          w_decay_cnt    = '0;
          w_winner       = 2'b00;
          w_countdown    = 2'd0;
          w_back_to_menu = 1'b1;
        end
      end
      default: begin
        w_state     = S_IDLE;
        w_xpos_p1   = START_X;
        w_xpos_p2   = START_X;
        w_speed_p1  = 4'd0;
        w_speed_p2  = 4'd0;
        w_frame_cnt = '0;
        w_decay_cnt = '0;
        w_winner    = 2'b00;
        w_countdown = 2'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_xpos_p1      <= START_X;
      r_xpos_p2      <= START_X;
      r_speed_p1     <= 4'd0;
      r_speed_p2     <= 4'd0;
      r_frame_cnt    <= '0;
      r_decay_cnt    <= '0;
      r_countdown    <= 2'd0;
      r_winner       <= 2'b00;
      r_race_active  <= 1'b0;
      r_done         <= 1'b0;
      r_back_to_menu <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_xpos_p1      <= w_xpos_p1;
      r_xpos_p2      <= w_xpos_p2;
      r_speed_p1     <= w_speed_p1;
      r_speed_p2     <= w_speed_p2;
      r_frame_cnt    <= w_frame_cnt;
      r_decay_cnt    <= w_decay_cnt;
      r_countdown    <= w_countdown;
      r_winner       <= w_winner;
      r_race_active  <= (w_state == S_RACE);
      r_done         <= (w_state == S_FINISH);
      r_back_to_menu <= w_back_to_menu;
    end
  end

  assign xpos_p1      = r_xpos_p1;
  assign xpos_p2      = r_xpos_p2;
  assign countdown    = r_countdown;
  assign race_active  = r_race_active;
  assign winner       = r_winner;
  assign done         = r_done;
  assign back_to_menu = r_back_to_menu;

endmodule

// File: tb/tb_race_controller.sv
// tb_race_controller: directed stimulus, a behavioural game model checked every
// cycle, plus hand-computed literal expectations.
module tb_race_controller;

  localparam int STEP = 2;
  localparam int DEC  = 8;
  localparam int SX   = 256;
  localparam int FX   = 900;
  localparam int MAXS = 15;
  localparam logic [3:0] K_P1 = 4'h1;
  localparam logic [3:0] K_P2 = 4'h2;
  localparam logic [3:0] K_EN = 4'h3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_game = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [10:0] xpos_p1, xpos_p2;
  logic [1:0]  countdown, winner;
  logic        race_active, done, back_to_menu;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  race_controller #(
    .START_X(11'd256), .FINISH_X(11'd900), .MAX_SPEED(4'd15),
    .STEP_FRAMES(STEP), .DECAY_FRAMES(DEC),
    .KEY_P1(K_P1), .KEY_P2(K_P2), .KEY_ENTER(K_EN)
  ) dut (
    .clk(clk), .rst(rst), .start_game(start_game), .frame_tick(frame_tick),
    .key_code(key_code), .xpos_p1(xpos_p1), .xpos_p2(xpos_p2),
    .countdown(countdown), .race_active(race_active), .winner(winner),
    .done(done), .back_to_menu(back_to_menu)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: phase 0 menu, 1 countdown, 2 racing, 3 finished.
  int m_ph, m_x1, m_x2, m_s1, m_s2, m_ct, m_rt, m_cd, m_win, m_btm;
  bit m_dec;

  function automatic int spd(input int s, input bit press, input bit dec);
    if (press && dec) return s;
    if (press) return (s + 1 > MAXS) ? MAXS : s + 1;
    if (dec) return (s > 0) ? s - 1 : 0;
    return s;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_x1 = SX; m_x2 = SX; m_s1 = 0; m_s2 = 0;
      m_ct = 0; m_rt = 0; m_cd = 0; m_win = 0; m_btm = 0;
    end else begin
      m_btm = 0;
      case (m_ph)
        0: if (start_game) begin m_ph = 1; m_ct = 0; m_cd = 3; m_win = 0; end
        1: begin
          if (key_code == K_P1) begin m_ph = 3; m_win = 2; end
          else if (key_code == K_P2) begin m_ph = 3; m_win = 1; end
          else if (frame_tick) begin
            m_ct++;
            m_cd = 3 - m_ct / STEP;
            if (m_ct == 3 * STEP) m_ph = 2;
          end
        end
        2: begin
          m_dec = 0;
          if (frame_tick) begin
            m_rt++;
            m_dec = (m_rt % (DEC + 1)) == 0;
            m_x1 = imin(m_x1 + m_s1, FX);
            m_x2 = imin(m_x2 + m_s2, FX);
          end
          m_s1 = spd(m_s1, key_code == K_P1, m_dec);
          m_s2 = spd(m_s2, key_code == K_P2, m_dec);
          if (m_x1 == FX || m_x2 == FX) begin
            m_win = (m_x1 == FX ? 1 : 0) + (m_x2 == FX ? 2 : 0);
            m_ph = 3;
          end
        end
        default: if (key_code == K_EN) begin
          m_ph = 0; m_btm = 1; m_x1 = SX; m_x2 = SX; m_s1 = 0; m_s2 = 0;
          m_ct = 0; m_rt = 0; m_win = 0; m_cd = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("xpos_p1", int'(xpos_p1), m_x1);
    chk("xpos_p2", int'(xpos_p2), m_x2);
    chk("countdown", int'(countdown), m_cd);
    chk("winner", int'(winner), m_win);
    chk("race_active", int'(race_active), (m_ph == 2) ? 1 : 0);
    chk("done", int'(done), (m_ph == 3) ? 1 : 0);
    chk("back_to_menu", int'(back_to_menu), m_btm);
  end

  // One clock of input, returning on the following falling edge.
  task automatic step(input logic t, input logic [3:0] k, input logic s);
    frame_tick = t; key_code = k; start_game = s;
    @(negedge clk);
    frame_tick = 1'b0; key_code = 4'h0; start_game = 1'b0;
  endtask

  task automatic run_to_finish(input string name);
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      step(1'b1, 4'h0, 1'b0);
    end
    chk(name, int'(done), 1);
  endtask

  int cd_exp [6] = '{3, 2, 2, 1, 1, 0};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_xpos_p1", int'(xpos_p1), 256);
    chk("reset_winner", int'(winner), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;

    // Menu ignores keys; countdown 3,3,2,2,1,1,0 then race.
    step(1'b0, K_P1, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    chk("cd_start", int'(countdown), 3);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'h0, 1'b0);
      chk("cd_seq", int'(countdown), cd_exp[i]);
    end
    chk("race_entered", int'(race_active), 1);

    // Speed saturation and decay.
    repeat (20) step(1'b0, K_P1, 1'b0);
    step(1'b1, 4'h0, 1'b0);
    chk("x_after_1tick", int'(xpos_p1), 271);
    repeat (8) step(1'b1, 4'h0, 1'b0);
    chk("x_after_9ticks", int'(xpos_p1), 391);
    step(1'b1, 4'h0, 1'b0);
    chk("x_speed14", int'(xpos_p1), 405);

    // Asynchronous reset mid-race.
    rst = 1'b1;
    #1;
    chk("rst_x1", int'(xpos_p1), 256);
    chk("rst_x2", int'(xpos_p2), 256);
    chk("rst_winner", int'(winner), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_race", int'(race_active), 0);
    @(negedge clk);
    rst = 1'b0;

    // Press and decay on the same tick.
    step(1'b0, 4'h0, 1'b1);
    repeat (6) step(1'b1, 4'h0, 1'b0);
    repeat (5) step(1'b0, K_P1, 1'b0);
    step(1'b0, 4'h7, 1'b0);
    step(1'b0, K_EN, 1'b0);
    repeat (8) step(1'b1, 4'h0, 1'b0);
    chk("x_speed5", int'(xpos_p1), 296);
    step(1'b1, K_P1, 1'b0);
    chk("x_press_decay", int'(xpos_p1), 301);
    step(1'b1, 4'h0, 1'b0);
    chk("x_speed_kept5", int'(xpos_p1), 306);

    // P1 wins with clamp; finish state ignores other inputs.
    repeat (10) step(1'b0, K_P1, 1'b0);
    run_to_finish("p1_finish_reached");
    chk("p1_clamp", int'(xpos_p1), 900);
    chk("p1_winner", int'(winner), 1);
    chk("p2_unmoved", int'(xpos_p2), 256);
    repeat (3) step(1'b1, K_P1, 1'b1);
    chk("p1_hold", int'(xpos_p1), 900);
    step(1'b0, K_EN, 1'b0);
    chk("menu_pulse", int'(back_to_menu), 1);
    step(1'b0, 4'h0, 1'b0);
    chk("menu_pulse_end", int'(back_to_menu), 0);
    chk("menu_x1", int'(xpos_p1), 256);

    // False start by P2 while countdown shows 2.
    step(1'b0, 4'h0, 1'b1);
    repeat (2) step(1'b1, 4'h0, 1'b0);
    chk("fs_cd2", int'(countdown), 2);
    step(1'b0, K_P2, 1'b0);
    chk("fs2_done", int'(done), 1);
    chk("fs2_winner", int'(winner), 1);
    chk("fs2_race", int'(race_active), 0);
    repeat (3) step(1'b1, 4'h0, 1'b0);
    step(1'b0, K_EN, 1'b0);
    chk("fs2_menu", int'(back_to_menu), 1);
    step(1'b0, 4'h0, 1'b0);

    // False start by P1 beats a simultaneous tick.
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, K_P1, 1'b0);
    chk("fs1_winner", int'(winner), 2);
    chk("fs1_cd", int'(countdown), 3);
    step(1'b0, K_EN, 1'b0);
    step(1'b0, 4'h0, 1'b0);

    // Tie: identical speeds reach the line on the same tick.
    step(1'b0, 4'h0, 1'b1);
    repeat (6) step(1'b1, 4'h0, 1'b0);
    repeat (15) begin
      step(1'b0, K_P1, 1'b0);
      step(1'b0, K_P2, 1'b0);
    end
    run_to_finish("tie_finish_reached");
    chk("tie_winner", int'(winner), 3);
    chk("tie_x1", int'(xpos_p1), 900);
    chk("tie_x2", int'(xpos_p2), 900);
    step(1'b0, K_EN, 1'b0);
    step(1'b0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
Game-flow sequencer for the drag race. Sits between the keyboard edge detector and the car/menu drawing pipeline and runs the flow IDLE -> COUNTDOWN -> RACE -> FINISH. It turns per-player key presses into car speed and horizontal position, detects false starts and the finish line, and reports the winner. All movement is frame-paced by an external one-cycle frame tick.

Parameters:
START_X, 256, reset/start x position of both cars (11 bit)
FINISH_X, 900, x position at which a car finishes (must be > START_X)
MAX_SPEED, 15, speed saturation value (speed register 4 bit)
STEP_FRAMES, 60, frame ticks per countdown step
DECAY_FRAMES, 8, frame ticks between automatic speed decrements
KEY_P1, 4'h1, key code for player 1 throttle
KEY_P2, 4'h2, key code for player 2 throttle
KEY_ENTER, 4'h3, key code that returns to the menu from FINISH

Ports:
clk  in  1  system clock (65 MHz pixel clock)
rst  in  1  asynchronous active-high reset
start_game  in  1  one-cycle pulse from the menu; starts the countdown
frame_tick  in  1  one-cycle pulse per video frame
key_code  in  4  one-cycle key press code; 0 = no key
xpos_p1  out  11  player 1 car x position
xpos_p2  out  11  player 2 car x position
countdown  out  2  countdown digit to display (3, 2, 1, then 0)
race_active  out  1  high in the RACE state
winner  out  2  00 none, 01 P1, 10 P2, 11 tie
done  out  1  high in the FINISH state
back_to_menu  out  1  one-cycle pulse on the FINISH -> IDLE transition

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - xpos_p1 and xpos_p2 = START_X.
  - Both speeds, the frame counter and the decay counter = 0.
  - countdown = 0, winner = 00, race_active = 0, done = 0, back_to_menu = 0.
- All outputs are registered. A state change is visible one clk after its trigger.
- IDLE:
  - Positions are held at START_X and speeds at 0.
  - start_game = 1 -> COUNTDOWN, with countdown = 3, frame counter = 0 and winner = 00.
  - key_code is ignored.
- COUNTDOWN:
  - Each frame_tick increments the frame counter.
  - When the counter reaches STEP_FRAMES, it clears and countdown decrements.
  - When the decrement takes countdown from 1 to 0, the next state is RACE.
  - With STEP_FRAMES = 2, RACE is entered on the cycle after the 6th frame_tick.
  - False start: key_code == KEY_P1 -> FINISH with winner = 10. key_code == KEY_P2 -> FINISH with winner = 01.
  - A false start takes priority over a frame_tick in the same cycle.
  - start_game is ignored.
- RACE (race_active = 1):
  - key_code == KEY_P1 adds 1 to the P1 speed, saturating at MAX_SPEED. P2 is the same with KEY_P2.
  - On a frame_tick, each xpos increases by its speed (11-bit add) and is clamped to FINISH_X.
  - On a frame_tick the decay counter also increments. When it reaches DECAY_FRAMES it clears, and every non-zero speed decrements by 1.
  - Key press and decay in the same cycle for the same player: speed is unchanged. If that speed is already MAX_SPEED it stays MAX_SPEED.
  - The position add uses the speed from before the update in the same cycle.
  - Finish is judged on the post-update positions. Only P1 reaches FINISH_X -> winner 01. Only P2 -> 10. Both on the same tick -> 11.
  - Any finish -> FINISH. Positions freeze at their clamped values.
- FINISH (done = 1):
  - Positions, speeds and winner are held.
  - key_code == KEY_ENTER -> IDLE. back_to_menu = 1 for exactly one cycle.
  - On entering IDLE, positions return to START_X, speeds and counters to 0, winner to 00, countdown to 0.
  - Other keys, start_game and frame_tick are ignored.
- Unknown key codes are ignored in every state.
- An unreachable state encoding recovers to IDLE.

Test Plan:
- Reset and countdown (STEP_FRAMES=2): assert rst mid-RACE with xpos_p1=400 -> xpos_p1=xpos_p2=256, winner=00, done=0. Then pulse start_game and send 6 frame ticks -> countdown reads 3,3,2,2,1,1,0 and race_active=1 after the 6th tick.
- False start: KEY_P2 pressed while countdown=2 -> done=1, winner=01, race_active never asserts. KEY_ENTER -> back_to_menu pulse of one cycle, then IDLE with xpos=256.
- Speed and decay (DECAY_FRAMES=8): in RACE, 20 KEY_P1 presses and no ticks -> speed 15. One frame_tick -> xpos_p1=271. Eight more ticks with no keys -> xpos_p1=391 and speed 14.
- Simultaneous decay and press: KEY_P1 arrives in the same cycle as the decaying tick, with speed 5 -> speed stays 5, and xpos advances by 5 on that tick.
- P1 win with clamp (FINISH_X=300, speed 15, xpos_p1=295) -> xpos_p1=300, winner=01, done=1. Later ticks change nothing.
- Tie: both cars within their speed of FINISH_X on the same tick -> winner=11 and both xpos=FINISH_X.
